// File: rtl/mc_main_control_if.sv
// Control bundle between the multicycle main-control FSM (master) and the MIPS datapath (slave).
interface mc_main_control_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       bad_op;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, zext, pcsource, aluop, bad_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, zext, pcsource, aluop, bad_op, state
    );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM; outputs are a Moore decode of the state register.
// Optional jump support is enabled by defining MC_JUMP_EN.
module mc_main_control (
    input  logic               clk,
    input  logic               rst_n,
    mc_main_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_IEX   = 4'd9,
        S_IWB   = 4'd10,
        S_JMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;

    function automatic logic op_legal(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: op_legal = 1'b1;
`ifdef MC_JUMP_EN
            OP_J:                                       op_legal = 1'b1;
`endif
            default:                                    op_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:    if (bus.mem_ready) state_q <= S_ID;
                S_ID: begin
                    case (bus.op)
                        OP_RTYPE:                              state_q <= S_REX;
                        OP_LW, OP_SW:                          state_q <= S_MADDR;
                        OP_BEQ, OP_BNE:                        state_q <= S_BR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                        OP_SLTI:                               state_q <= S_IEX;
`ifdef MC_JUMP_EN
                        OP_J:                                  state_q <= S_JMP;
`endif
                        default:                               state_q <= S_IF;
                    endcase
                end
                S_MADDR: state_q <= (bus.op == OP_SW) ? S_MWR : S_MRD;
                S_MRD:   if (bus.mem_ready) state_q <= S_MWB;
                S_MWR:   if (bus.mem_ready) state_q <= S_IF;
                S_REX:   state_q <= S_RWB;
                S_IEX:   state_q <= S_IWB;
                // Every other reachable state, and any stray encoding, returns to fetch.
                default: state_q <= S_IF;
            endcase
        end
    end

    // Outputs are held at zero for the whole time rst_n is low, not just after the next edge.
    always_comb begin
        bus.pc_en    = 1'b0;
        bus.iord     = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.zext     = 1'b0;
        bus.pcsource = 2'b00;
        bus.aluop    = 2'b00;
        bus.bad_op   = 1'b0;
        bus.state    = 4'd0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    bus.memread = 1'b1;
                    bus.alusrcb = 2'b01;
                    bus.irwrite = bus.mem_ready;
                    bus.pc_en   = bus.mem_ready;
                    bus.state   = state_q;
                end
                S_ID: begin
                    bus.alusrcb = 2'b11;
                    bus.bad_op  = ~op_legal(bus.op);
                    bus.state   = state_q;
                end
                S_MADDR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    bus.state   = state_q;
                end
                S_MRD: begin
                    bus.memread = 1'b1;
                    bus.iord    = 1'b1;
                    bus.state   = state_q;
                end
                S_MWB: begin
                    bus.memtoreg = 1'b1;
                    bus.regwrite = 1'b1;
                    bus.state    = state_q;
                end
                S_MWR: begin
                    bus.memwrite = 1'b1;
                    bus.iord     = 1'b1;
                    bus.state    = state_q;
                end
                S_REX: begin
                    bus.alusrca = 1'b1;
                    bus.aluop   = 2'b10;
                    bus.state   = state_q;
                end
                S_RWB: begin
                    bus.regdst   = 1'b1;
                    bus.regwrite = 1'b1;
                    bus.state    = state_q;
                end
                S_BR: begin
                    // op[0] distinguishes bne (1) from beq (0).
                    bus.alusrca  = 1'b1;
                    bus.pcsource = 2'b01;
                    bus.aluop    = bus.op[0] ? 2'b11 : 2'b01;
                    bus.pc_en    = bus.op[0] ? ~bus.zero : bus.zero;
                    bus.state    = state_q;
                end
                S_IEX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    bus.aluop   = 2'b10;
                    bus.zext    = (bus.op == OP_ANDI) || (bus.op == OP_ORI) || (bus.op == OP_XORI);
                    bus.state   = state_q;
                end
                S_IWB: begin
                    bus.regwrite = 1'b1;
                    bus.state    = state_q;
                end
`ifdef MC_JUMP_EN
                S_JMP: begin
                    bus.pc_en    = 1'b1;
                    bus.pcsource = 2'b10;
                    bus.state    = state_q;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: directed instruction sequences with hand-written per-cycle expectations.
module tb_mc_main_control;
    logic clk;
    logic rst_n;
    mc_main_control_if bus();

    mc_main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Vector order: pc_en iord memread memwrite irwrite regdst memtoreg regwrite alusrca alusrcb zext pcsource aluop bad_op state
    function automatic logic [20:0] ev(input logic pc, input logic io, input logic mr, input logic mw,
                                       input logic ir, input logic rd, input logic m2r, input logic rw,
                                       input logic sa, input logic [1:0] sb, input logic zx,
                                       input logic [1:0] ps, input logic [1:0] ao, input logic bo,
                                       input logic [3:0] st);
        return {pc, io, mr, mw, ir, rd, m2r, rw, sa, sb, zx, ps, ao, bo, st};
    endfunction

    function automatic logic [20:0] e_zero();   return '0; endfunction
    function automatic logic [20:0] e_if(input logic rdy);
        return ev(rdy, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 4'd0);
    endfunction
    function automatic logic [20:0] e_id(input logic b);
        return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, b, 4'd1);
    endfunction
    function automatic logic [20:0] e_maddr(); return ev(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,2'b00,0,4'd2); endfunction
    function automatic logic [20:0] e_mrd();   return ev(0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,4'd3); endfunction
    function automatic logic [20:0] e_mwb();   return ev(0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,2'b00,0,4'd4); endfunction
    function automatic logic [20:0] e_mwr();   return ev(0,1,0,1,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,4'd5); endfunction
    function automatic logic [20:0] e_rex();   return ev(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,2'b10,0,4'd6); endfunction
    function automatic logic [20:0] e_rwb();   return ev(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,2'b00,0,4'd7); endfunction
    function automatic logic [20:0] e_br(input logic pc, input logic [1:0] ao);
        return ev(pc, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, ao, 0, 4'd8);
    endfunction
    function automatic logic [20:0] e_iex(input logic zx);
        return ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, zx, 2'b00, 2'b10, 0, 4'd9);
    endfunction
    function automatic logic [20:0] e_iwb();   return ev(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,2'b00,0,4'd10); endfunction
    function automatic logic [20:0] e_jmp();   return ev(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00,0,4'd11); endfunction

    // One clock cycle of stimulus; inputs change just after the rising edge.
    task automatic cyc(input logic r, input logic [5:0] o, input logic z, input logic rdy,
                       input logic chk, input logic [20:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.op        = o;
        bus.zero      = z;
        bus.mem_ready = rdy;
        if (chk) begin
            x.v  = e;
            x.nm = nm;
            q.push_back(x);
        end
    endtask

    // Monitor: the DUT presents a decoded control word every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [20:0] obs;
            x   = q.pop_front();
            obs = {bus.pc_en, bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.regdst,
                   bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.zext,
                   bus.pcsource, bus.aluop, bus.bad_op, bus.state};
            total++;
            if (obs !== x.v) begin
                bad++;
                $display("FAIL %s: got %b expected %b", x.nm, obs, x.v);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.op        = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) cyc(0, 6'b000000, 1, 1, 1, e_zero(), "reset_hold");
        cyc(1, 6'b000000, 0, 0, 0, e_zero(), "release");
        cyc(1, 6'b000000, 0, 0, 1, e_if(0), "if_wait_after_reset");

        // lw, zero-wait: 5 cycles
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "lw_if");
        cyc(1, 6'b100011, 0, 1, 1, e_id(0),    "lw_id");
        cyc(1, 6'b100011, 0, 1, 1, e_maddr(),  "lw_maddr");
        cyc(1, 6'b100011, 0, 1, 1, e_mrd(),    "lw_mrd");
        cyc(1, 6'b100011, 0, 1, 1, e_mwb(),    "lw_mwb");

        // sw with two wait states in MWR
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "sw_if");
        cyc(1, 6'b101011, 0, 1, 1, e_id(0),    "sw_id");
        cyc(1, 6'b101011, 0, 1, 1, e_maddr(),  "sw_maddr");
        cyc(1, 6'b101011, 0, 0, 1, e_mwr(),    "sw_mwr_wait1");
        cyc(1, 6'b101011, 0, 0, 1, e_mwr(),    "sw_mwr_wait2");
        cyc(1, 6'b101011, 0, 1, 1, e_mwr(),    "sw_mwr_done");

        // R-type, with mem_ready low outside IF to show it is ignored there
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "r_if");
        cyc(1, 6'b000000, 0, 0, 1, e_id(0),    "r_id");
        cyc(1, 6'b000000, 0, 0, 1, e_rex(),    "r_rex");
        cyc(1, 6'b000000, 0, 0, 1, e_rwb(),    "r_rwb");

        // beq taken, beq not taken, bne with zero=1
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "beq_if");
        cyc(1, 6'b000100, 0, 1, 1, e_id(0),    "beq_id");
        cyc(1, 6'b000100, 1, 1, 1, e_br(1, 2'b01), "beq_taken");
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "beq2_if");
        cyc(1, 6'b000100, 0, 1, 1, e_id(0),    "beq2_id");
        cyc(1, 6'b000100, 0, 1, 1, e_br(0, 2'b01), "beq_not_taken");
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "bne_if");
        cyc(1, 6'b000101, 1, 1, 1, e_id(0),    "bne_id");
        cyc(1, 6'b000101, 1, 1, 1, e_br(0, 2'b11), "bne_zero1");

        // ori (zero-extended) and addi (sign-extended)
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "ori_if");
        cyc(1, 6'b001101, 0, 1, 1, e_id(0),    "ori_id");
        cyc(1, 6'b001101, 0, 1, 1, e_iex(1),   "ori_iex");
        cyc(1, 6'b001101, 0, 1, 1, e_iwb(),    "ori_iwb");
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "addi_if");
        cyc(1, 6'b001000, 0, 1, 1, e_id(0),    "addi_id");
        cyc(1, 6'b001000, 0, 1, 1, e_iex(0),   "addi_iex");
        cyc(1, 6'b001000, 0, 1, 1, e_iwb(),    "addi_iwb");

        // jump
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "j_if");
`ifdef MC_JUMP_EN
        cyc(1, 6'b000010, 0, 1, 1, e_id(0),    "j_id");
        cyc(1, 6'b000010, 0, 1, 1, e_jmp(),    "j_jmp");
`else
        cyc(1, 6'b000010, 0, 1, 1, e_id(1),    "j_id_illegal");
`endif
        cyc(1, 6'b000000, 0, 0, 1, e_if(0),    "j_back_to_if");

        // illegal opcode: 2 cycles, then fetch again
        cyc(1, 6'b000000, 0, 1, 1, e_if(1),    "ill_if");
        cyc(1, 6'b111111, 0, 1, 1, e_id(1),    "ill_id");
        cyc(1, 6'b111111, 0, 1, 1, e_if(1),    "ill_back_to_if");

        // lw aborted by reset while waiting in MRD
        cyc(1, 6'b100011, 0, 1, 1, e_id(0),    "abort_id");
        cyc(1, 6'b100011, 0, 1, 1, e_maddr(),  "abort_maddr");
        cyc(1, 6'b100011, 0, 0, 1, e_mrd(),    "abort_mrd_wait");
        cyc(0, 6'b100011, 0, 0, 1, e_zero(),   "abort_async_reset");
        cyc(0, 6'b100011, 0, 1, 1, e_zero(),   "abort_reset_hold");
        cyc(1, 6'b000000, 0, 0, 0, e_zero(),   "abort_release");
        cyc(1, 6'b000000, 0, 0, 1, e_if(0),    "abort_refetch");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multicycle main control FSM for the MIPS core. It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also produces the 2-bit `aluop` that the ALU-control decoder turns into a 3-bit ALU operation. Memory accesses wait on a ready handshake, so instruction and data memories may insert wait states.

## Interface
- No parameters. State encoding is internal, 4 bits.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `op` in 6: opcode, IR[31:26]. Valid from state ID onward.
- `zero` in 1: ALU zero flag (result == 0).
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_en` out 1: PC load enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `memread`, `memwrite` out 1 each: memory strobes.
- `irwrite` out 1: IR load.
- `regdst` out 1: 1 = rd, 0 = rt.
- `memtoreg` out 1: 1 = MDR, 0 = ALUOut.
- `regwrite` out 1: register file write.
- `alusrca` out 1: 0 = PC, 1 = A.
- `alusrcb` out 2: 00 = B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `zext` out 1: zero-extend imm (andi/ori/xori).
- `pcsource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = beq/sub, 11 = bne, 10 = decode op/funct.
- `bad_op` out 1: one-cycle pulse, unsupported opcode seen in ID.
- `state` out 4: current state, debug only.

## Operation
- Moore FSM. All outputs are decoded combinationally from the state register, plus `mem_ready`, `zero` and `op` where noted. Any signal not listed for a state is 0.
- IF
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite = pc_en = mem_ready.
  - Next state: ID if mem_ready, else hold IF.
- ID
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Dispatch on `op`:
    - 000000 → REX.
    - 100011 (lw) or 101011 (sw) → MADDR.
    - 000100 / 000101 → BR.
    - 001000, 001100, 001101, 001110, 001010 → IEX.
    - 000010 → JMP (see Configuration).
    - Any other opcode: bad_op=1, next state IF, no register or memory side effects.
- MADDR
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next state: MRD for lw, MWR for sw.
- MRD
  - Outputs: memread=1, iord=1.
  - Next state: MWB on mem_ready, else hold.
- MWB
  - Outputs: regdst=0, memtoreg=1, regwrite=1.
  - Next state: IF.
- MWR
  - Outputs: memwrite=1, iord=1.
  - Next state: IF on mem_ready, else hold.
- REX
  - Outputs: alusrca=1, alusrcb=00, aluop=10.
  - Next state: RWB.
- RWB
  - Outputs: regdst=1, memtoreg=0, regwrite=1.
  - Next state: IF.
- BR
  - Outputs: alusrca=1, alusrcb=00, pcsource=01.
  - aluop = 01 for beq, 11 for bne.
  - pc_en = zero for beq, ~zero for bne.
  - Next state: IF.
- IEX
  - Outputs: alusrca=1, alusrcb=10, aluop=10.
  - zext=1 iff op ∈ {001100, 001101, 001110}.
  - Next state: IWB.
- IWB
  - Outputs: regdst=0, memtoreg=0, regwrite=1.
  - Next state: IF.
- JMP
  - Outputs: pc_en=1, pcsource=10.
  - Next state: IF.
- Unreachable state encodings → IF on the next edge. All outputs are 0 while in an unreachable encoding.

## Timing
- Reset: while rst_n=0, the state is IF and every output is forced to 0, including `state`=0.
  - The first IF cycle is the first rising edge after rst_n rises.
- Reset asserted mid-instruction aborts it immediately. No write strobe may remain high after rst_n falls.
- Cycles per instruction with zero-wait memory:
  - lw 5; sw 4; R-type 4; I-type 4; branch 3; jump 3; illegal opcode 2.
- Each cycle of mem_ready=0 in IF, MRD or MWR adds one cycle to the instruction.
- memread / memwrite / iord stay constant across wait cycles.
- irwrite and pc_en in IF are high only in the cycle mem_ready=1. Exactly one PC+4 update happens per fetch.
- mem_ready is ignored in every other state.
- `zero` is sampled only in BR and only affects pc_en. The transition BR→IF is unconditional.

## Configuration
- `MC_JUMP_EN` defined:
  - op 000010 goes to JMP.
  - pcsource=10 is used.
- `MC_JUMP_EN` undefined:
  - The JMP state is not built.
  - op 000010 is handled as an illegal opcode: bad_op pulse, return to IF.
  - pcsource is never 10.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. After release, state=IF with memread=1 and alusrcb=01.
- lw, op=100011, mem_ready tied 1 → IF, ID, MADDR, MRD, MWB in 5 cycles. regwrite=1 with memtoreg=1 only in cycle 5.
- sw with mem_ready=0 for 2 cycles in MWR → memwrite held high for 3 cycles, iord=1 throughout, then IF.
- beq with zero=1 → pc_en=1, pcsource=01, aluop=01. bne with zero=1 → pc_en=0, aluop=11.
- ori, op=001101 → IEX shows aluop=10, zext=1, alusrcb=10. IWB shows regwrite=1, regdst=0.
- op=000010 → JMP with pc_en=1 when MC_JUMP_EN is defined. bad_op pulse and return to IF when it is not. Also pull rst_n low during MRD → outputs go to 0 asynchronously.
